// File: rtl/l1_refill_dma.sv
// L1 line-refill engine: one AXI4 read burst per miss, each beat written to inst_mem or data_mem.
// Optional macro L1_REFILL_CWF_EN selects critical-word-first (WRAP burst plus crit_valid output).
module l1_refill_dma #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_target,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [ADDR_WIDTH-1:0] dma_inst_mem_waddr,
    output logic [DATA_WIDTH-1:0] dma_inst_mem_wdata,
    output logic                  inst_mem_write,
    output logic [ADDR_WIDTH-1:0] dma_data_mem_waddr,
    output logic [DATA_WIDTH-1:0] dma_data_mem_wdata,
    output logic                  data_mem_write,
    output logic                  data_mem_write_ctrl_by,
`ifdef L1_REFILL_CWF_EN
    output logic                  crit_valid,
`endif
    output logic [1:0]            dbg_state
);
    localparam int CW   = $clog2(BURST_LEN);
    localparam int OFFS = CW + 2;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_target;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [CW-1:0]         r_beat;
    logic                  r_err;
    logic                  r_inst_we;
    logic                  r_data_we;
    logic                  r_crit;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_req_fire;
    logic                  w_beat_fire;
    logic                  w_last_cnt;
    logic                  w_burst_end;
    logic                  w_bad;
    logic [CW-1:0]         w_idx;
    logic                  w_unused_addr;

    assign w_req_fire    = req_valid && (r_state == S_IDLE);
    assign w_beat_fire   = m_axi_rvalid && (r_state == S_DATA);
    assign w_last_cnt    = (r_beat == CW'(BURST_LEN - 1));
    assign w_burst_end   = w_beat_fire && (w_last_cnt || m_axi_rlast);
    // Both early rlast and missing rlast show up as rlast disagreeing with the beat count.
    assign w_bad         = (m_axi_rresp != 2'b00) || (m_axi_rlast != w_last_cnt);
    // Low araddr word bits are zero for INCR, so this wraps only in critical-word-first mode.
    assign w_idx         = r_araddr[OFFS-1:2] + r_beat;
    assign w_unused_addr = ^req_addr[OFFS-1:0];

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)     w_next = S_ADDR;
            S_ADDR:  if (m_axi_arready) w_next = S_DATA;
            S_DATA:  if (w_burst_end)   w_next = S_DONE;
            S_DONE:                     w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready              = 1'b0;
        busy                   = 1'b1;
        done                   = 1'b0;
        err                    = 1'b0;
        m_axi_arvalid          = 1'b0;
        m_axi_rready           = 1'b0;
        data_mem_write_ctrl_by = r_target;
        case (r_state)
            S_IDLE: begin
                req_ready              = 1'b1;
                busy                   = 1'b0;
                data_mem_write_ctrl_by = 1'b0;
            end
            S_ADDR:  m_axi_arvalid = 1'b1;
            S_DATA:  m_axi_rready  = 1'b1;
            S_DONE: begin
                done = 1'b1;
                err  = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_target  <= 1'b0;
            r_araddr  <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_inst_we <= 1'b0;
            r_data_we <= 1'b0;
            r_crit    <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_inst_we <= 1'b0;
            r_data_we <= 1'b0;
            r_crit    <= 1'b0;
            if (w_req_fire) begin
                r_target <= req_target;
`ifdef L1_REFILL_CWF_EN
                r_araddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
`else
                r_araddr <= {req_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
`endif
                r_beat   <= '0;
                r_err    <= 1'b0;
            end
            if (w_beat_fire) begin
                r_beat    <= r_beat + CW'(1);
                r_err     <= r_err | w_bad;
                r_inst_we <= !r_target;
                r_data_we <= r_target;
                r_crit    <= (r_beat == '0);
                r_waddr   <= {r_araddr[ADDR_WIDTH-1:OFFS], w_idx, 2'b00};
                r_wdata   <= m_axi_rdata;
            end
        end
    end

    assign m_axi_araddr       = r_araddr;
    assign m_axi_arlen        = 8'(BURST_LEN - 1);
    assign m_axi_arsize       = 3'b010;
`ifdef L1_REFILL_CWF_EN
    assign m_axi_arburst      = 2'b10;
    assign crit_valid         = r_crit;
`else
    assign m_axi_arburst      = 2'b01;
`endif
    assign dma_inst_mem_waddr = r_waddr;
    assign dma_inst_mem_wdata = r_wdata;
    assign inst_mem_write     = r_inst_we;
    assign dma_data_mem_waddr = r_waddr;
    assign dma_data_mem_wdata = r_wdata;
    assign data_mem_write     = r_data_we;
    assign dbg_state          = r_state;
endmodule

// File: doc/l1_refill_dma.md
Name: l1_refill_dma

Overview:
- Line-refill engine between the L1 cache and the external AXI memory.
- On a miss request, issues one AXI4 INCR read burst of BURST_LEN words.
- Writes each returned beat into either the inst_mem or the data_mem DMA write port, then reports completion with one `done` pulse.
- Drives the DMA-side write/ctrl_by inputs of the L1 memories.

Parameters:
- DATA_WIDTH, 32, word width; AXI data width equals this.
- ADDR_WIDTH, 32, byte address width.
- BURST_LEN, 8, words per line; power of 2, range 2..16.

Ports:
- cpu_clk  in  1  single clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  refill request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH  miss byte address.
- req_target  in  1  0 = inst_mem, 1 = data_mem.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; 1 = bad rresp or rlast mismatch.
- m_axi_araddr  out  ADDR_WIDTH  burst start address.
- m_axi_arlen  out  8  BURST_LEN-1.
- m_axi_arsize  out  3  constant 3'b010.
- m_axi_arburst  out  2  INCR (2'b01).
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- dma_inst_mem_waddr  out  ADDR_WIDTH  inst_mem write address.
- dma_inst_mem_wdata  out  DATA_WIDTH  inst_mem write data.
- inst_mem_write  out  1  inst_mem write strobe.
- dma_data_mem_waddr  out  ADDR_WIDTH  data_mem write address.
- dma_data_mem_wdata  out  DATA_WIDTH  data_mem write data.
- data_mem_write  out  1  data_mem write strobe.
- data_mem_write_ctrl_by  out  1  1 while busy with req_target=1.

Behaviour:
- Reset: state IDLE; every output 0 except req_ready=1 and the constant arlen/arsize/arburst. Reset mid-burst drops the state asynchronously to IDLE; no further write strobes; remaining R beats are not accepted (rready=0). The AXI slave shares this reset.
- FSM is IDLE -> ADDR -> DATA -> DONE -> IDLE.
- IDLE: a request is accepted when req_valid && req_ready.
  - Latch target.
  - base = req_addr with the low log2(BURST_LEN*4) bits cleared.
  - Clear beat counter and err accumulator. Next state ADDR.
- ADDR: arvalid=1; araddr=base is held stable until arready. Transfer completes on arvalid && arready; next state DATA, arvalid=0 next cycle.
- DATA:
  - rready=1.
  - A beat is accepted on rvalid && rready at cycle n. Registered write at n+1: strobe of the latched target high for one cycle, waddr = base + 4*beat, wdata = rdata.
  - The other target's strobe stays 0.
  - Beat counter increments per beat.
  - rresp != 2'b00 sets the err accumulator. The data is still written.
- Burst end:
  - The beat with beat == BURST_LEN-1, or any beat with rlast=1, ends DATA; next state DONE.
  - Early rlast sets err.
  - Missing rlast on beat BURST_LEN-1 sets err.
- DONE (one cycle):
  - done=1; err = accumulator. This is the same cycle as the final write strobe.
  - rready=0.
  - Next state IDLE. req_ready is high the following cycle, so back-to-back requests have one idle cycle between done and acceptance.
- data_mem_write_ctrl_by = busy && target; it drops with the transition to IDLE.
- No rvalid without a prior AR is tolerated: rready=0 outside DATA.

Optional Feature:
- Macro L1_REFILL_CWF_EN: critical word first.
- Defined:
  - araddr = req_addr with only bits [1:0] cleared; arburst = WRAP (2'b10).
  - Beat k is written to base + ((word_off + k) mod BURST_LEN)*4.
  - Extra output crit_valid (1 bit) pulses with the first write strobe.
- Undefined: INCR from the aligned base as above; crit_valid is absent.

Test Plan:
- Inst refill: req_addr=0x0000_0104, target=0, arready immediate, rvalid every cycle, rdata 0xA0..0xA7, rlast on beat 7 -> araddr=0x100, arlen=7. Eight inst_mem_write pulses at 0x100..0x11C with data 0xA0..0xA7. done=1 with the last strobe, err=0. data_mem_write never high.
- Data refill, arready delayed 3 cycles, rvalid gaps every other cycle -> arvalid held with araddr stable for 4 cycles. data_mem_write only the cycle after each beat. data_mem_write_ctrl_by=1 from ADDR through DONE, then 0.
- rresp=2'b10 on beat 3 -> all 8 words written, done with err=1.
- rlast on beat 5 -> 6 writes, done after the sixth, err=1. Later requests are unaffected.
- cpu_rst_n low during beat 4 -> busy, rready and the strobes are 0 immediately, req_ready=1. The next request refills 0x200 correctly.
- CWF_EN, req_addr=0x10C -> araddr=0x10C, arburst=2'b10. Writes go to 0x10C, 0x110..0x11C, then 0x100..0x108. crit_valid pulses with the first write only.
